// File: rtl/mmio_pkg.sv
// Shared register map and status bit layout for the MMIO UART hub.
`timescale 1ns/1ps
package mmio_pkg;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_RX_POP  = 8'h04;
    localparam logic [7:0] ADDR_TX_PUSH = 8'h08;
    localparam logic [7:0] ADDR_COUNT   = 8'h0C;
    localparam logic [7:0] ADDR_CYCLE   = 8'h10;
    localparam logic [7:0] ADDR_INSTR   = 8'h14;
    localparam logic [7:0] ADDR_CNT_CLR = 8'h18;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_TX_DROP      = 2;
    localparam int STAT_RX_UNDER     = 3;
    localparam int STAT_TX_EMPTY     = 4;

    function automatic logic [31:0] pack_status(
        input logic tx_not_full,
        input logic rx_not_empty,
        input logic tx_drop,
        input logic rx_under,
        input logic tx_empty
    );
        logic [31:0] s;
        s                    = '0;
        s[STAT_TX_NOT_FULL]  = tx_not_full;
        s[STAT_RX_NOT_EMPTY] = rx_not_empty;
        s[STAT_TX_DROP]      = tx_drop;
        s[STAT_RX_UNDER]     = rx_under;
        s[STAT_TX_EMPTY]     = tx_empty;
        return s;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count; head word is visible on rdata_o (zero when empty).
`timescale 1ns/1ps
module fifo_sync #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO front end for an RX/TX byte FIFO pair plus free-running cycle and retired-instruction counters.
`timescale 1ns/1ps
module mmio_uart_hub
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_we,
    input  logic        io_re,
    input  logic [31:0] d,
    input  logic        inst_valid,
    output logic [31:0] q,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       off;
    logic             wr_en, rx_rd, tx_wr, sticky_clr, cnt_clr;
    logic [7:0]       rx_head, tx_head;
    logic [CW-1:0]    rx_count, tx_count;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_under, tx_push, tx_pop, tx_drop;
    logic             drop_q, drop_d, under_q, under_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
    logic [31:0]      rdata, q_q, q_d;
    logic             unused_bits;

    assign off         = io_addr[7:0];
    assign wr_en       = |io_we;
    assign unused_bits = ^{io_addr[31:8], d[31:8]};

    // Both byte streams transfer on a rising edge where valid and ready are both high;
    // ready/valid here depend only on registered FIFO occupancy, never on the partner's signal.
    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_head;
    assign q        = q_q;

    assign rx_rd      = io_re & (off == ADDR_RX_POP);
    assign rx_pop     = rx_rd & ~rx_empty;
    assign rx_under   = rx_rd & rx_empty;
    assign rx_push    = rx_valid & ~rx_full;
    assign tx_wr      = wr_en & (off == ADDR_TX_PUSH);
    assign tx_push    = tx_wr & ~tx_full;
    assign tx_drop    = tx_wr & tx_full;
    assign tx_pop     = tx_valid & tx_ready;
    assign sticky_clr = wr_en & (off == ADDR_COUNT);
    assign cnt_clr    = wr_en & (off == ADDR_CNT_CLR);

    fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (rx_data),
        .rdata_o (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (d[7:0]),
        .rdata_o (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // Read data reflects state before this edge's pushes and pops.
    always_comb begin
        rdata = '0;
        case (off)
            ADDR_STATUS: rdata = pack_status(~tx_full, ~rx_empty, drop_q, under_q, tx_empty);
            ADDR_RX_POP: rdata = {24'h0, rx_head};
            ADDR_COUNT:  rdata = {16'h0, 8'(tx_count), 8'(rx_count)};
            ADDR_CYCLE:  rdata = 32'(cyc_q);
            ADDR_INSTR:  rdata = 32'(inst_q);
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        q_d     = io_re ? rdata : q_q;
        drop_d  = tx_drop | (drop_q & ~sticky_clr);
        under_d = rx_under | (under_q & ~sticky_clr);
        cyc_d   = cnt_clr ? '0 : cyc_q + CNT_W'(1);
        inst_d  = cnt_clr ? '0 : inst_q + CNT_W'(inst_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q     <= '0;
            drop_q  <= 1'b0;
            under_q <= 1'b0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            q_q     <= q_d;
            drop_q  <= drop_d;
            under_q <= under_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Bench for mmio_uart_hub: queue-based reference model, per-cycle compare, directed and random traffic.
`timescale 1ns/1ps
module tb_mmio_uart_hub;

    localparam int DEPTH = 8;
    localparam int CNTW  = 4;
    localparam int CMASK = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] io_addr = '0;
    logic [3:0]  io_we = '0;
    logic        io_re = 1'b0;
    logic [31:0] d = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] q;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmio_uart_hub #(.FIFO_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .io_we      (io_we),
        .io_re      (io_re),
        .d          (d),
        .inst_valid (inst_valid),
        .q          (q),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    bit          m_drop = 1'b0;
    bit          m_under = 1'b0;
    int          m_cyc = 0;
    int          m_inst = 0;
    logic [31:0] m_q = '0;

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00: return {27'd0, m_tx.size() == 0, m_under, m_drop, m_rx.size() != 0, m_tx.size() < DEPTH};
            8'h04: return (m_rx.size() > 0) ? {24'd0, m_rx[0]} : 32'd0;
            8'h0C: return {16'd0, 8'(m_tx.size()), 8'(m_rx.size())};
            8'h10: return 32'(m_cyc);
            8'h14: return 32'(m_inst);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rx.delete();
            m_tx.delete();
            m_drop  = 1'b0;
            m_under = 1'b0;
            m_cyc   = 0;
            m_inst  = 0;
            m_q     = '0;
        end else begin
            automatic logic [7:0] off = io_addr[7:0];
            automatic bit wr       = |io_we;
            automatic bit rx_pop   = io_re && off == 8'h04 && m_rx.size() > 0;
            automatic bit rx_und   = io_re && off == 8'h04 && m_rx.size() == 0;
            automatic bit rx_push  = rx_valid && m_rx.size() < DEPTH;
            automatic bit tx_wr    = wr && off == 8'h08;
            automatic bit tx_full  = m_tx.size() == DEPTH;
            automatic bit tx_pop   = m_tx.size() > 0 && tx_ready;
            automatic bit s_clr    = wr && off == 8'h0C;
            automatic bit c_clr    = wr && off == 8'h18;
            if (io_re) m_q = model_read(off);
            if (rx_pop) void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(rx_data);
            if (tx_pop) void'(m_tx.pop_front());
            if (tx_wr && !tx_full) m_tx.push_back(d[7:0]);
            m_drop  = (tx_wr && tx_full) || (m_drop && !s_clr);
            m_under = rx_und || (m_under && !s_clr);
            m_cyc   = c_clr ? 0 : (m_cyc + 1) & CMASK;
            m_inst  = c_clr ? 0 : (m_inst + int'(inst_valid)) & CMASK;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        check("q", q, m_q);
        check("tx_valid", 32'(tx_valid), 32'(m_tx.size() > 0));
        check("tx_data", 32'(tx_data), (m_tx.size() > 0) ? 32'(m_tx[0]) : 32'd0);
        check("rx_ready", 32'(rx_ready), 32'(m_rx.size() < DEPTH));
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic mmio_read(input logic [7:0] a, output logic [31:0] v);
        io_addr = {24'd0, a};
        io_re   = 1'b1;
        @(negedge clk);
        io_re   = 1'b0;
        v       = q;
    endtask

    task automatic mmio_write(input logic [7:0] a, input logic [31:0] dv);
        io_addr = {24'd0, a};
        d       = dv;
        io_we   = 4'hF;
        @(negedge clk);
        io_we   = 4'h0;
    endtask

    task automatic idle_inputs();
        io_we      = 4'h0;
        io_re      = 1'b0;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        inst_valid = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] prev;
    int          wraps;
    logic [31:0] addrs [10];

    initial begin
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h40, 32'h104};

        // reset state
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_q", q, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // two RX bytes, count, pop both, status
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        @(negedge clk);
        rx_data  = 8'h42;
        @(negedge clk);
        rx_valid = 1'b0;
        mmio_read(8'h0C, v); check("rx_count_2", v, 32'h0000_0002);
        mmio_read(8'h04, v); check("rx_pop_41", v, 32'h41);
        mmio_read(8'h04, v); check("rx_pop_42", v, 32'h42);
        mmio_read(8'h00, v); check("status_rx_empty", v, 32'h11);

        // RX underflow
        mmio_read(8'h04, v); check("rx_under_q", v, 32'h0);
        mmio_read(8'h00, v); check("status_under", v, 32'h19);
        mmio_read(8'h0C, v); check("rx_count_0", v, 32'h0);
        mmio_write(8'h0C, 32'h0);
        mmio_read(8'h00, v); check("status_under_clr", v, 32'h11);

        // TX overflow with tx_ready low
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) mmio_write(8'h08, 32'hA0 + 32'(i));
        mmio_read(8'h0C, v); check("tx_count_8", v, 32'h0000_0800);
        mmio_read(8'h00, v); check("status_tx_drop", v, 32'h04);
        check("tx_head_a0", 32'(tx_data), 32'hA0);
        mmio_write(8'h0C, 32'h0);
        mmio_read(8'h00, v); check("status_drop_clr", v, 32'h00);
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        tx_ready = 1'b0;
        mmio_read(8'h00, v); check("status_tx_drained", v, 32'h11);

        // RX full, push and pop in the same cycle
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        check("rx_full_ready", 32'(rx_ready), 32'h0);
        rx_data = 8'hEE;
        mmio_read(8'h04, v);
        rx_valid = 1'b0;
        check("full_pop_q", v, 32'h10);
        check("full_pop_ready", 32'(rx_ready), 32'h1);
        mmio_read(8'h0C, v); check("rx_count_7", v, 32'h0000_0007);
        mmio_read(8'h04, v); check("rx_after_full", v, 32'h11);
        for (int i = 0; i < 6; i++) mmio_read(8'h04, v);
        check("rx_last", v, 32'h17);

        // cycle counter wrap and clear priority
        io_addr = 32'h10;
        io_re   = 1'b1;
        wraps   = 0;
        @(negedge clk);
        prev = q;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (prev == 32'd15 && q == 32'd0) wraps++;
            prev = q;
        end
        io_re = 1'b0;
        check("cyc_wrap_once", 32'(wraps), 32'd1);
        mmio_write(8'h18, 32'h0);
        mmio_read(8'h10, v); check("cyc_clr_0", v, 32'd0);
        mmio_read(8'h10, v); check("cyc_clr_1", v, 32'd1);
        mmio_write(8'h18, 32'h0);
        inst_valid = 1'b1;
        repeat (5) @(negedge clk);
        inst_valid = 1'b0;
        mmio_read(8'h14, v); check("inst_5", v, 32'd5);

        // randomized traffic with one mid-stream reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #2 rst = 1'b1;
            end
            io_addr    = addrs[$urandom_range(0, 9)];
            io_we      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (io_addr == 32'h18 && $urandom_range(0, 7) != 0) io_we = 4'h0;
            io_re      = 1'($urandom_range(0, 1));
            d          = $urandom;
            rx_valid   = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rx_data    = 8'($urandom);
            tx_ready   = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            inst_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        idle_inputs();

        // reset with bytes queued in TX
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) mmio_write(8'h08, 32'h30 + 32'(i));
        check("tx3_valid", 32'(tx_valid), 32'h1);
        mmio_read(8'h0C, v); check("tx_count_3", v, 32'h0000_0300);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_mid_tx_data", 32'(tx_data), 32'h0);
        check("rst_mid_q", q, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        mmio_read(8'h0C, v); check("tx_count_after_rst", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
